// File: rtl/bcd_seq_conv.sv
// Iterative double-dabble binary-to-BCD converter with start/done handshake.
// Optional leading-zero blanking is enabled by defining BCD_BLANK_EN.
module bcd_seq_conv #(
  parameter int          IN_W       = 18,
  parameter int          DIGITS     = 6,
  parameter logic [3:0]  BLANK_CODE = 4'hA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [IN_W-1:0]       i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_W + 1);

`ifdef BCD_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  // Largest value representable in DIGITS decimal digits, fixed at elaboration.
  localparam logic [63:0] MAXV = pow10(DIGITS) - 64'd1;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t          r_state;
  logic [IN_W-1:0] r_shift;
  logic [BW-1:0]   r_scr;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf_pend;

  logic [63:0]     w_bin_ext;
  logic            w_ovf_in;
  logic [BW-1:0]   w_adj;
  logic [BW-1:0]   w_scr_nxt;
  logic [BW-1:0]   w_fmt;
  logic [BW-1:0]   w_res;
  logic            w_last;

  assign w_bin_ext = 64'(i_bin);
  assign w_ovf_in  = (w_bin_ext > MAXV);
  assign w_last    = (r_cnt == CW'(IN_W - 1));

  always_comb begin
    w_adj = r_scr;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_scr[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_scr[4*d +: 4] + 4'd3;
    end
  end

  // Top scratch bit falls off; only meaningful when the value overflows.
  assign w_scr_nxt = {w_adj[BW-2:0], r_shift[IN_W-1]};

  always_comb begin
    logic lead;
    w_fmt = r_scr;
    lead  = 1'b1;
    if (BLANK_EN) begin
      for (int d = DIGITS - 1; d >= 1; d--) begin
        if (lead && (r_scr[4*d +: 4] == 4'd0)) w_fmt[4*d +: 4] = BLANK_CODE;
        else                                    lead = 1'b0;
      end
    end
  end

  assign w_res = r_ovf_pend ? {DIGITS{4'h9}} : w_fmt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_scr      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_bcd      <= '0;
      o_ovf      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          o_busy <= 1'b0;
          if (i_start) begin
            r_shift    <= i_bin;
            r_scr      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= w_ovf_in;
            o_busy     <= 1'b1;
            r_state    <= S_CONV;
          end
        end
        S_CONV: begin
          r_scr   <= w_scr_nxt;
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) r_state <= S_DONE;
        end
        S_DONE: begin
          // busy stays high through the done pulse; IDLE drops it next edge.
          o_bcd   <= w_res;
          o_ovf   <= r_ovf_pend;
          o_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
